wash_phase_scheduler: RTL and testbench
=======================================

Name: wash_phase_scheduler

Overview:
- Sequences one washing-machine program through its water-in, wash, drain, rinse and spin phases using a one-second tick strobe.
- Drives the valve, motor and buzzer controls.
- Exports per-phase and total remaining seconds for the seven-segment display path.
- Sits between the front-panel inputs (mode, weight, start/pause) and the light/display datapath.

Parameters:
- FILL_UNIT, 2, fill seconds per weight level
- DRAIN_UNIT, 2, drain seconds per weight level
- WASH_T, 9, wash seconds
- RINSE_T, 6, rinse seconds
- SPIN_T, 6, spin seconds
- BUZZ_T, 3, end-of-program buzzer seconds
- All parameters must be >=1.

Ports:
- clk  in  1  system clock; the only clock in the block
- rst  in  1  synchronous reset, active-low
- tick  in  1  one-cycle strobe, one per second
- start_pause  in  1  one-cycle pulse: start, pause/resume, or buzzer acknowledge
- mode  in  3  {wash, rinse, spin} enable mask
- weight  in  2  load level 1..3; value 0 is treated as 1
- phase  out  4  0 IDLE, 1 FILL_W, 2 WASH, 3 DRAIN_W, 4 FILL_R, 5 RINSE, 6 DRAIN_R, 7 SPIN, 8 DONE
- running  out  1  in a phase 1..7 and not paused
- paused  out  1  pause flag
- valve_in  out  1  water inlet
- valve_out  out  1  water outlet
- motor  out  1  drum motor
- buzzer  out  1  end buzzer
- phase_left  out  8  seconds left in current phase
- total_left  out  8  seconds left in program; excludes buzzer time

Behaviour:
- Reset (rst==0 at a clk edge):
  - phase=IDLE; paused, valve_in, valve_out, motor and buzzer all 0.
  - phase_left and total_left are 0; the latched mode and weight are cleared.
  - Reset applies in any state, including mid-program; no phase is resumed afterwards.
- Valid modes: 100, 110, 111, 010, 011, 001. Modes 000 and 101 are invalid; a start_pause pulse in IDLE with an invalid mode is ignored.
- Start (start_pause in IDLE, mode valid):
  - Latch mode and weight.
  - On the next cycle, phase = first enabled phase, phase_left = its duration, total_left = sum of all scheduled durations.
  - mode and weight changes are ignored until the block returns to IDLE.
- Durations (w = latched weight):
  - FILL_*: w*FILL_UNIT
  - DRAIN_*: w*DRAIN_UNIT
  - WASH: WASH_T; RINSE: RINSE_T; SPIN: SPIN_T
  - Maximum program length at defaults is 45 seconds, which fits in 8 bits.
- Phase order:
  - Wash enabled: FILL_W -> WASH -> DRAIN_W.
  - Rinse enabled: FILL_R -> RINSE -> DRAIN_R.
  - Spin enabled: SPIN.
  - Disabled groups are skipped. After the last phase, go to DONE with phase_left=BUZZ_T.
- Tick handling (phases 1..7, not paused):
  - phase_left>1: decrement phase_left and total_left.
  - phase_left==1: advance to the next phase, load its duration, decrement total_left.
  - Update latency is 1 cycle after tick.
  - Ticks in IDLE or while paused are dropped, not queued.
- DONE:
  - buzzer=1; each tick decrements phase_left.
  - At phase_left==1 a tick returns the block to IDLE, clears phase_left and drops the buzzer.
  - start_pause in DONE acknowledges: return to IDLE the next cycle.
- Pause:
  - start_pause in phases 1..7 toggles paused.
  - While paused, valve_in, valve_out and motor are 0 and both counters are frozen.
- Simultaneous start_pause and tick in the same cycle: start_pause wins and the tick is discarded.
- Output decode (when not paused):
  - valve_in = FILL_W|FILL_R
  - valve_out = DRAIN_W|DRAIN_R|SPIN
  - motor = WASH|RINSE|SPIN
  - All outputs are registered.

Test Plan:
- Reset, mode=111, weight=1, start -> FILL_W, phase_left=2, total_left=29. After 29 ticks -> DONE, buzzer=1. After 3 more ticks -> IDLE, buzzer=0.
- mode=010, weight=2, start -> FILL_R, phase_left=4, total_left=14. After 3 ticks: 1/11. Pause, then 5 ticks -> 1/11 unchanged, valve_in=0. Resume, then 1 tick -> RINSE, phase_left=6, total_left=10, motor=1.
- mode=101 or 000, start pulse -> phase stays IDLE, all outputs 0. During a run, change mode/weight -> no effect on sequence or counters.
- mode=001, weight=3, start -> SPIN, phase_left=6, valve_out=1, motor=1. After 6 ticks -> DONE. start_pause in DONE -> IDLE next cycle.
- Running mode=100, start_pause and tick in the same cycle -> paused=1, counters unchanged.
- rst=0 mid-WASH -> next cycle phase=IDLE, all outputs 0. A subsequent start is accepted normally.

Source files
------------

// File: rtl/wash_phase_scheduler_if.sv
// Front-panel inputs and control/display outputs of the wash phase scheduler.
interface wash_phase_scheduler_if;
   logic       tick;
   logic       start_pause;
   logic [2:0] mode;
   logic [1:0] weight;
   logic [3:0] phase;
   logic       running;
   logic       paused;
   logic       valve_in;
   logic       valve_out;
   logic       motor;
   logic       buzzer;
   logic [7:0] phase_left;
   logic [7:0] total_left;

   // Panel/testbench side drives the inputs.
   modport master (
      output tick, start_pause, mode, weight,
      input  phase, running, paused, valve_in, valve_out, motor, buzzer,
             phase_left, total_left
   );

   // Scheduler side.
   modport slave (
      input  tick, start_pause, mode, weight,
      output phase, running, paused, valve_in, valve_out, motor, buzzer,
             phase_left, total_left
   );
endinterface

// File: rtl/wash_phase_scheduler.sv
// Sequences one wash program (fill/wash/drain, fill/rinse/drain, spin) on a 1 s tick.
module wash_phase_scheduler #(
   parameter int unsigned FILL_UNIT  = 2,
   parameter int unsigned DRAIN_UNIT = 2,
   parameter int unsigned WASH_T     = 9,
   parameter int unsigned RINSE_T    = 6,
   parameter int unsigned SPIN_T     = 6,
   parameter int unsigned BUZZ_T     = 3
) (
   input logic                    clk,
   input logic                    rst,
   wash_phase_scheduler_if.slave  bus
);

   localparam int unsigned CW = 8;

   localparam logic [CW-1:0] FILL_U  = CW'(FILL_UNIT);
   localparam logic [CW-1:0] DRAIN_U = CW'(DRAIN_UNIT);
   localparam logic [CW-1:0] WASH_D  = CW'(WASH_T);
   localparam logic [CW-1:0] RINSE_D = CW'(RINSE_T);
   localparam logic [CW-1:0] SPIN_D  = CW'(SPIN_T);
   localparam logic [CW-1:0] BUZZ_D  = CW'(BUZZ_T);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FILL_W  = 4'd1,
      WASH    = 4'd2,
      DRAIN_W = 4'd3,
      FILL_R  = 4'd4,
      RINSE   = 4'd5,
      DRAIN_R = 4'd6,
      SPIN    = 4'd7,
      DONE    = 4'd8
   } phase_e;

   phase_e        phase_q, phase_d;
   logic          paused_q, paused_d;
   logic [2:0]    mode_q, mode_d;
   logic [1:0]    weight_q, weight_d;
   logic [CW-1:0] phase_left_q, phase_left_d;
   logic [CW-1:0] total_left_q, total_left_d;
   logic          running_q, running_d;
   logic          valve_in_q, valve_in_d;
   logic          valve_out_q, valve_out_d;
   logic          motor_q, motor_d;
   logic          buzzer_q, buzzer_d;

   function automatic logic mode_valid(input logic [2:0] m);
      return (m != 3'b000) && (m != 3'b101);
   endfunction

   // Phases 1..3 belong to the wash group, 4..6 to rinse, 7 to spin.
   function automatic logic phase_enabled(input int i, input logic [2:0] m);
      if (i <= 3)      return m[2];
      else if (i <= 6) return m[1];
      else             return m[0];
   endfunction

   // First enabled phase strictly after cur; DONE when none remains.
   function automatic phase_e next_phase(input phase_e cur, input logic [2:0] m);
      phase_e nxt;
      nxt = DONE;
      for (int i = 7; i >= 1; i--) begin
         if (i > int'(cur) && phase_enabled(i, m)) nxt = phase_e'(4'(i));
      end
      return nxt;
   endfunction

   function automatic logic [CW-1:0] eff_weight(input logic [1:0] w);
      return (w == 2'd0) ? CW'(1) : CW'(w);
   endfunction

   function automatic logic [CW-1:0] duration(input phase_e p, input logic [1:0] w);
      case (p)
         FILL_W, FILL_R:   return eff_weight(w) * FILL_U;
         DRAIN_W, DRAIN_R: return eff_weight(w) * DRAIN_U;
         WASH:             return WASH_D;
         RINSE:            return RINSE_D;
         SPIN:             return SPIN_D;
         DONE:             return BUZZ_D;
         default:          return '0;
      endcase
   endfunction

   function automatic logic [CW-1:0] program_len(input logic [2:0] m, input logic [1:0] w);
      logic [CW-1:0] sum;
      sum = '0;
      if (m[2]) sum = sum + duration(FILL_W, w) + WASH_D + duration(DRAIN_W, w);
      if (m[1]) sum = sum + duration(FILL_R, w) + RINSE_D + duration(DRAIN_R, w);
      if (m[0]) sum = sum + SPIN_D;
      return sum;
   endfunction

   // Next-state: start/pause has priority over tick in every state.
   always_comb begin
      phase_d      = phase_q;
      paused_d     = paused_q;
      mode_d       = mode_q;
      weight_d     = weight_q;
      phase_left_d = phase_left_q;
      total_left_d = total_left_q;

      if (phase_q == IDLE) begin
         if (bus.start_pause && mode_valid(bus.mode)) begin
            mode_d       = bus.mode;
            weight_d     = bus.weight;
            phase_d      = next_phase(IDLE, bus.mode);
            phase_left_d = duration(phase_d, bus.weight);
            total_left_d = program_len(bus.mode, bus.weight);
         end
      end else if (phase_q == DONE) begin
         if (bus.start_pause || (bus.tick && phase_left_q <= CW'(1))) begin
            phase_d      = IDLE;
            phase_left_d = '0;
            total_left_d = '0;
         end else if (bus.tick) begin
            phase_left_d = phase_left_q - CW'(1);
         end
      end else begin
         if (bus.start_pause) begin
            paused_d = !paused_q;
         end else if (bus.tick && !paused_q) begin
            total_left_d = total_left_q - CW'(1);
            if (phase_left_q > CW'(1)) begin
               phase_left_d = phase_left_q - CW'(1);
            end else begin
               phase_d      = next_phase(phase_q, mode_q);
               phase_left_d = duration(phase_d, weight_q);
            end
         end
      end

      // Outputs decoded from the next state so they leave on flops.
      running_d   = (phase_d != IDLE) && (phase_d != DONE) && !paused_d;
      valve_in_d  = !paused_d && (phase_d == FILL_W || phase_d == FILL_R);
      valve_out_d = !paused_d && (phase_d == DRAIN_W || phase_d == DRAIN_R || phase_d == SPIN);
      motor_d     = !paused_d && (phase_d == WASH || phase_d == RINSE || phase_d == SPIN);
      buzzer_d    = (phase_d == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_q      <= IDLE;
         paused_q     <= 1'b0;
         mode_q       <= '0;
         weight_q     <= '0;
         phase_left_q <= '0;
         total_left_q <= '0;
         running_q    <= 1'b0;
         valve_in_q   <= 1'b0;
         valve_out_q  <= 1'b0;
         motor_q      <= 1'b0;
         buzzer_q     <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         paused_q     <= paused_d;
         mode_q       <= mode_d;
         weight_q     <= weight_d;
         phase_left_q <= phase_left_d;
         total_left_q <= total_left_d;
         running_q    <= running_d;
         valve_in_q   <= valve_in_d;
         valve_out_q  <= valve_out_d;
         motor_q      <= motor_d;
         buzzer_q     <= buzzer_d;
      end
   end

   assign bus.phase      = 4'(phase_q);
   assign bus.paused     = paused_q;
   assign bus.running    = running_q;
   assign bus.valve_in   = valve_in_q;
   assign bus.valve_out  = valve_out_q;
   assign bus.motor      = motor_q;
   assign bus.buzzer     = buzzer_q;
   assign bus.phase_left = phase_left_q;
   assign bus.total_left = total_left_q;

endmodule

// File: tb/tb_wash_phase_scheduler.sv
// Directed bench for wash_phase_scheduler at default parameters.
module tb_wash_phase_scheduler;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   wash_phase_scheduler_if bus ();

   wash_phase_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // flags = {running, paused, valve_in, valve_out, motor, buzzer}
   task automatic chk_state(input string tag, input int ph, input int pl, input int tl,
                            input logic [5:0] flags);
      logic [5:0] f;
      f = {bus.running, bus.paused, bus.valve_in, bus.valve_out, bus.motor, bus.buzzer};
      chk({tag, ".phase"}, int'(bus.phase), ph);
      chk({tag, ".phase_left"}, int'(bus.phase_left), pl);
      chk({tag, ".total_left"}, int'(bus.total_left), tl);
      chk({tag, ".flags"}, int'(f), int'(flags));
   endtask

   task automatic press();
      @(negedge clk) bus.start_pause = 1'b1;
      @(negedge clk) bus.start_pause = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge clk) bus.tick = 1'b1;
         @(negedge clk) bus.tick = 1'b0;
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      bus.tick = 1'b0;
      bus.start_pause = 1'b0;
      bus.mode = 3'b111;
      bus.weight = 2'd1;
      repeat (3) @(negedge clk);
      chk_state("reset", 0, 0, 0, 6'b000000);
      rst = 1'b1;
      @(negedge clk);

      // Full program, mode 111, weight 1.
      ticks(1);
      chk_state("idle_tick", 0, 0, 0, 6'b000000);
      press();
      chk_state("m111_start", 1, 2, 29, 6'b101000);
      ticks(2);
      chk_state("m111_wash", 2, 9, 27, 6'b100010);
      ticks(27);
      chk_state("m111_done", 8, 3, 0, 6'b000001);
      ticks(2);
      chk_state("m111_buzz", 8, 1, 0, 6'b000001);
      ticks(1);
      chk_state("m111_idle", 0, 0, 0, 6'b000000);

      // Rinse only, weight 2, with pause and mid-run input changes.
      bus.mode = 3'b010;
      bus.weight = 2'd2;
      press();
      chk_state("m010_start", 4, 4, 14, 6'b101000);
      ticks(3);
      chk_state("m010_t3", 4, 1, 11, 6'b101000);
      press();
      bus.mode = 3'b111;
      bus.weight = 2'd3;
      ticks(5);
      chk_state("m010_paused", 4, 1, 11, 6'b010000);
      press();
      chk_state("m010_resume", 4, 1, 11, 6'b101000);
      ticks(1);
      chk_state("m010_rinse", 5, 6, 10, 6'b100010);
      ticks(6);
      chk_state("m010_drain", 6, 4, 4, 6'b100100);
      ticks(4);
      chk_state("m010_done", 8, 3, 0, 6'b000001);
      press();
      chk_state("m010_ack", 0, 0, 0, 6'b000000);

      // Invalid modes are ignored.
      bus.mode = 3'b101;
      press();
      chk_state("m101_ignored", 0, 0, 0, 6'b000000);
      bus.mode = 3'b000;
      press();
      chk_state("m000_ignored", 0, 0, 0, 6'b000000);

      // Spin only, weight 3.
      bus.mode = 3'b001;
      bus.weight = 2'd3;
      press();
      chk_state("m001_start", 7, 6, 6, 6'b100110);
      ticks(6);
      chk_state("m001_done", 8, 3, 0, 6'b000001);
      press();
      chk_state("m001_ack", 0, 0, 0, 6'b000000);

      // Wash only, weight 0 (treated as 1); start_pause beats a coincident tick.
      bus.mode = 3'b100;
      bus.weight = 2'd0;
      press();
      chk_state("m100_start", 1, 2, 13, 6'b101000);
      @(negedge clk) begin
         bus.start_pause = 1'b1;
         bus.tick = 1'b1;
      end
      @(negedge clk) begin
         bus.start_pause = 1'b0;
         bus.tick = 1'b0;
      end
      chk_state("m100_sp_tick", 1, 2, 13, 6'b010000);
      press();
      ticks(2);
      chk_state("m100_wash", 2, 9, 11, 6'b100010);
      ticks(3);
      chk_state("m100_wash3", 2, 6, 8, 6'b100010);

      // Reset mid-WASH, then a fresh start.
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      chk_state("mid_reset", 0, 0, 0, 6'b000000);
      bus.mode = 3'b011;
      bus.weight = 2'd1;
      press();
      chk_state("m011_start", 4, 2, 16, 6'b101000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
